// File: rtl/sram_word_ctrl.sv
// Word-access initiator for a byte-wide synchronous SRAM.
// Each 32-bit host request becomes four little-endian byte accesses.
module sram_word_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-3:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_datain,
  input  logic [7:0]        mem_dataout
);

  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_DRAIN = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WA_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_datain_q, mem_datain_d;

  // State register with the latched request and read assembly buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; read bytes land one cycle behind the address
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          state_d = req_we ? WR : RD;
        end
      end
      WR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      RD: begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd1:    rdata_d[7:0]   = mem_dataout;
          2'd2:    rdata_d[15:8]  = mem_dataout;
          2'd3:    rdata_d[23:16] = mem_dataout;
          default: ;
        endcase
        if (idx_q == 2'd3) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        rdata_d[31:24] = mem_dataout;
        state_d        = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    mem_we_d     = (state_d == WR);
    mem_read_d   = (state_d == RD);
    mem_cs_d     = mem_we_d || mem_read_d;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    resp_rdata_d = resp_rdata_q;
    if (mem_cs_d) mem_addr_d = {addr_d, idx_d};
    if (mem_we_d) mem_datain_d = 8'(wdata_d >> {idx_d, 3'b000});
    if (state_q == RD_DRAIN) resp_rdata_d = rdata_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= 8'd0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: byte-wide SRAM model plus word-level reference memory.
module tb_sram_word_ctrl;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-3:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_datain;
  logic [7:0]        mem_dataout;

  int errors = 0;
  int checks = 0;

  bit   [7:0]  sram [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  sram_word_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Synchronous byte SRAM: write on strobe, registered read data
  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_datain;
    if (mem_cs && mem_read) mem_dataout <= sram[mem_addr];
  end

  always @(negedge clk) begin
    checks++;
    assert (!(mem_we === 1'b1 && mem_read === 1'b1)) else begin
      errors++;
      $error("FAIL we_read_overlap: observed we=%0b read=%0b required not both 1", mem_we, mem_read);
    end
    checks++;
    assert (mem_cs === (mem_we | mem_read)) else begin
      errors++;
      $error("FAIL cs_decode: observed cs=%0b required %0b", mem_cs, mem_we | mem_read);
    end
  end

  function automatic logic [31:0] ref_rd(input logic [ADDR_W-3:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Present a request in an IDLE cycle; returns in the first busy cycle
  task automatic start(input bit we, input logic [ADDR_W-3:0] a, input logic [31:0] d,
                       input bit hold);
    for (int i = 0; i < 16 && req_ready !== 1'b1; i++) cyc();
    chk("accept_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (we) ref_mem[int'(a)] = d;
    cyc();
    if (!hold) req_valid = 1'b0;
  endtask

  // Check the four byte beats, the response and the return to IDLE
  task automatic finish(input bit we, input logic [ADDR_W-3:0] a, input logic [31:0] d,
                        input bit pulse);
    for (int k = 0; k < 4; k++) begin
      if (pulse && k == 1) begin
        req_valid = 1'b1;
        req_we    = ~we;
        req_addr  = a ^ 15'h1234;
        req_wdata = ~d;
      end
      if (pulse && k == 2) req_valid = 1'b0;
      chk("beat_cs", 64'(mem_cs), 64'd1);
      chk("beat_we", 64'(mem_we), 64'(we));
      chk("beat_read", 64'(mem_read), 64'(!we));
      chk("beat_addr", 64'(mem_addr), 64'({a, 2'(k)}));
      if (we) chk("beat_data", 64'(mem_datain), 64'(d[8*k +: 8]));
      chk("beat_ready", 64'(req_ready), 64'd0);
      chk("beat_resp", 64'(resp_valid), 64'd0);
      cyc();
    end
    if (!we) begin
      chk("drain_cs", 64'(mem_cs), 64'd0);
      chk("drain_resp", 64'(resp_valid), 64'd0);
      cyc();
    end
    chk("done_resp", 64'(resp_valid), 64'd1);
    chk("done_ready", 64'(req_ready), 64'd0);
    chk("done_cs", 64'(mem_cs), 64'd0);
    if (!we) last_rd = ref_rd(a);
    chk("done_rdata", 64'(resp_rdata), 64'(last_rd));
    cyc();
    chk("idle_resp", 64'(resp_valid), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_cs", 64'(mem_cs), 64'd0);
  endtask

  initial begin
    bit                we;
    logic [ADDR_W-3:0] a;
    logic [31:0]       d;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 32'd0;
    last_rd = 32'd0;
    cyc(); cyc();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp", 64'(resp_valid), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_strobes", 64'({mem_cs, mem_we, mem_read}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_datain", 64'(mem_datain), 64'd0);
    rst = 1'b0;
    cyc();

    // Directed write then read-back
    start(1'b1, 15'h0005, 32'hDEADBEEF, 1'b0);
    finish(1'b1, 15'h0005, 32'hDEADBEEF, 1'b0);
    chk("sram_0x14", 64'({sram[17'h17], sram[17'h16], sram[17'h15], sram[17'h14]}), 64'hDEADBEEF);
    start(1'b0, 15'h0005, 32'd0, 1'b0);
    finish(1'b0, 15'h0005, 32'd0, 1'b0);
    chk("readback_5", 64'(last_rd), 64'hDEADBEEF);

    // Back-to-back with req_valid held high, top word
    start(1'b1, 15'h7FFF, 32'h01234567, 1'b1);
    req_we   = 1'b0;
    req_addr = 15'h7FFF;
    finish(1'b1, 15'h7FFF, 32'h01234567, 1'b0);
    start(1'b0, 15'h7FFF, 32'd0, 1'b0);
    finish(1'b0, 15'h7FFF, 32'd0, 1'b0);
    chk("readback_7fff", 64'(last_rd), 64'h01234567);
    chk("no_wrap_low", 64'({sram[17'h3], sram[17'h2], sram[17'h1], sram[17'h0]}), 64'h0);

    // Reset in the third cycle of a write
    start(1'b1, 15'h0000, 32'h11223344, 1'b0);
    finish(1'b1, 15'h0000, 32'h11223344, 1'b0);
    start(1'b1, 15'h0000, 32'hAABBCCDD, 1'b0);
    chk("abort_beat0", 64'(mem_we), 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_strobes", 64'({mem_cs, mem_we, mem_read}), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_rdata", 64'(resp_rdata), 64'd0);
    last_rd = 32'd0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
      cyc();
    end
    chk("abort_bytes", 64'({sram[17'h3], sram[17'h2], sram[17'h1], sram[17'h0]}), 64'h1122CCDD);
    ref_mem[0] = 32'h1122CCDD;
    start(1'b0, 15'h0000, 32'd0, 1'b0);
    finish(1'b0, 15'h0000, 32'd0, 1'b0);

    // Reset during a read: no response
    start(1'b0, 15'h0005, 32'd0, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    last_rd = 32'd0;
    for (int i = 0; i < 8; i++) begin
      chk("rdabort_no_resp", 64'(resp_valid), 64'd0);
      chk("rdabort_rdata", 64'(resp_rdata), 64'd0);
      cyc();
    end

    // Requests pulsed while busy must be ignored
    start(1'b1, 15'h0042, 32'hCAFEF00D, 1'b0);
    finish(1'b1, 15'h0042, 32'hCAFEF00D, 1'b1);
    start(1'b0, 15'h0042, 32'd0, 1'b0);
    finish(1'b0, 15'h0042, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("pulse_idle_cs", 64'(mem_cs), 64'd0);
      cyc();
    end
    start(1'b0, 15'h0042 ^ 15'h1234, 32'd0, 1'b0);
    finish(1'b0, 15'h0042 ^ 15'h1234, 32'd0, 1'b0);

    // Randomized traffic against the reference array
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
      d  = $urandom;
      start(we, a, d, 1'b0);
      finish(we, a, d, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Word-access initiator for the byte-wide synchronous SRAM: accepts 32-bit read/write requests from a host over a valid/ready handshake and sequences each into four byte accesses on the SRAM port (`cs`/`we`/`read`/8-bit data). It is the front end placed between the processor-side bus and one byte-wide SRAM lane. Byte order is little-endian: byte k of a word occupies bits [8k+7:8k] and sits at SRAM byte address {word_addr, k}.

## Interface
- `ADDR_W`, 17: SRAM byte-address width. The word address is `ADDR_W-2` bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: host request present.
- `req_ready`  out  1: controller can accept a request. High only in IDLE.
- `req_we`  in  1: 1 = write word, 0 = read word.
- `req_addr`  in  ADDR_W-2: word address.
- `req_wdata`  in  32: write data.
- `resp_valid`  out  1: one-cycle pulse marking completion of the accepted request (read or write).
- `resp_rdata`  out  32: read word. Valid while `resp_valid`=1 after a read, and held until the next read completes.
- `mem_cs`  out  1: SRAM chip select.
- `mem_we`  out  1: SRAM write strobe.
- `mem_read`  out  1: SRAM read strobe.
- `mem_addr`  out  ADDR_W: SRAM byte address.
- `mem_datain`  out  8: byte driven to the SRAM.
- `mem_dataout`  in  8: byte returned by the SRAM. It is registered in the SRAM and updates at the edge that ends the read cycle.

## Operation
- FSM states: IDLE, WR, RD, RD_DRAIN, DONE. A 2-bit byte counter `idx` is used in WR and RD.
- **IDLE**
  - `req_ready`=1; all `mem_*` strobes are 0.
  - On `req_valid & req_ready`: latch `req_we`, `req_addr`, `req_wdata`; clear `idx` to 0; go to WR if `req_we`=1, otherwise RD.
- **WR**
  - `mem_cs`=1, `mem_we`=1, `mem_read`=0.
  - `mem_addr`={addr,idx}; `mem_datain`=wdata[8·idx+7:8·idx].
  - `idx` increments every cycle. When `idx`=3, go to DONE.
- **RD**
  - `mem_cs`=1, `mem_read`=1, `mem_we`=0; `mem_addr`={addr,idx}.
  - Starting with the second RD cycle, capture `mem_dataout` into byte `idx-1` of the read register at each edge.
  - When `idx`=3, go to RD_DRAIN.
- **RD_DRAIN**
  - All strobes 0.
  - Capture `mem_dataout` into byte 3 at the edge ending this cycle; go to DONE.
- **DONE**
  - `resp_valid`=1 and `req_ready`=0.
  - `resp_rdata` presents the assembled word after a read. After a write it retains its previous value.
  - Return to IDLE.
- **Strobe rules**
  - `mem_we` and `mem_read` are never 1 in the same cycle.
  - `mem_cs`=0 whenever neither strobe is active.
  - When idle, `mem_addr` and `mem_datain` hold their last values. Their content does not matter while `mem_cs`=0.
- **Request handling**
  - While busy, `req_valid` is ignored: no queuing and no error.
  - The host must hold the request until it sees `req_ready`=1.
- **Reset**
  - Asserted in any state, including mid-burst: at the next edge, go to IDLE, drive all strobes and `resp_valid` to 0, and clear `resp_rdata` to 0.
  - Bytes already written by an aborted write stay in the SRAM and are not rolled back. An aborted read produces no response.
- **Reset values of outputs:** `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `mem_cs`=`mem_we`=`mem_read`=0, `mem_addr`=0, `mem_datain`=0.
- **Wrap-around:** address arithmetic never carries out of the word. The last word (all ones) uses bytes {all ones, 0..3}.

## Timing
- Handshake at edge E (end of cycle T), where T is the IDLE cycle.
- Write:
  - Strobes are active in cycles T+1 to T+4 (bytes 0 to 3).
  - `resp_valid` is high in T+5.
  - `req_ready` rises in T+6.
  - Each write takes 6 cycles, handshake to handshake.
- Read:
  - Strobes are active in cycles T+1 to T+4.
  - Byte k appears on `mem_dataout` in cycle T+2+k and is captured at the end of that cycle.
  - RD_DRAIN occupies T+5.
  - `resp_valid` and the final `resp_rdata` appear in T+6.
  - `req_ready` rises in T+7.
  - Each read takes 7 cycles.
- All outputs are driven from registers or decoded from state only. There is no combinational path from `req_*` to `mem_*` or to `resp_*`.

## Test plan
- Reset, then write addr 0x0005 with data 0xDEADBEEF:
  - `mem_addr` 0x00014..0x00017 carries 0xEF, 0xBE, 0xAD, 0xDE in T+1 to T+4 with `mem_we`=1.
  - `resp_valid` is high in T+5 only.
- Read back addr 0x0005 through a byte-wide SRAM model:
  - `mem_read` is high in T+1 to T+4.
  - `resp_rdata`=0xDEADBEEF with `resp_valid` in T+6.
  - `mem_we` stays 0 throughout.
- Back-to-back operations with `req_valid` held high (write 0x7FFF/0x01234567, then read 0x7FFF):
  - The second request is accepted only in the cycle after DONE.
  - The read returns 0x01234567.
  - Byte addresses 0x1FFFC..0x1FFFF do not wrap.
- Assert `rst` in T+2 of a write to 0x0000 with data 0xAABBCCDD:
  - Next cycle shows all strobes 0 and `req_ready`=1.
  - The model shows bytes 0 and 1 written and bytes 2 and 3 unchanged.
  - No `resp_valid` is produced.
- `req_valid` pulsed while busy with a different address:
  - The pulse is ignored.
  - The SRAM access sequence and the response match the original request only.
- Randomized write/read of 200 words against a reference array:
  - Every read matches.
  - `mem_we & mem_read` is never 1.
